// File: rtl/icache_fetch_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
// Imported by the cache top and its storage array.
package icache_fetch_pkg;

    localparam int ICACHE_INDEX_WIDTH = 8;
    localparam int ICACHE_ADDR_WIDTH  = 32;
    localparam int ICACHE_TAG_WIDTH   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2;
    localparam int ICACHE_INST_WIDTH  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write,
// valid bits cleared asynchronously; tag/data are never reset.
module icache_array
    import icache_fetch_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = ICACHE_TAG_WIDTH,
    parameter int DATA_WIDTH  = ICACHE_INST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    output logic                   o_rd_valid,
    output logic [TAG_WIDTH-1:0]   o_rd_tag,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_we,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0]  i_wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache: 1-cycle hits, misses fetched over the
// memory controller's instruction handshake, flush drops stale fills.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         if_req_valid,
    input  logic [ADDR_WIDTH-1:0]        if_req_addr,
    output logic                         if_req_ready,
    output logic                         if_rsp_valid,
    output logic [ICACHE_INST_WIDTH-1:0] if_rsp_inst,
    input  logic                         flush,
    output logic                         mc_req,
    output logic [ADDR_WIDTH-1:0]        mc_addr,
    input  logic                         mc_done,
    input  logic [ICACHE_INST_WIDTH-1:0] mc_data
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    icache_state_t                r_state;
    logic                         r_rsp_valid;
    logic [ICACHE_INST_WIDTH-1:0] r_rsp_inst;
    logic                         r_mc_req;
    logic [ADDR_WIDTH-1:0]        r_mc_addr;
    logic                         r_drop;
    logic [INDEX_WIDTH-1:0]       r_idx;
    logic [TAG_WIDTH-1:0]         r_tag;

    icache_state_t                w_state_n;
    logic                         w_rsp_valid_n;
    logic [ICACHE_INST_WIDTH-1:0] w_rsp_inst_n;
    logic                         w_mc_req_n;
    logic [ADDR_WIDTH-1:0]        w_mc_addr_n;
    logic                         w_drop_n;
    logic [INDEX_WIDTH-1:0]       w_idx_n;
    logic [TAG_WIDTH-1:0]         w_tag_n;

    logic                         w_ready;
    logic                         w_accept;
    logic                         w_hit;
    logic                         w_we;
    logic [INDEX_WIDTH-1:0]       w_rd_idx;
    logic [TAG_WIDTH-1:0]         w_req_tag;
    logic                         w_line_valid;
    logic [TAG_WIDTH-1:0]         w_line_tag;
    logic [ICACHE_INST_WIDTH-1:0] w_line_data;
    logic                         w_unused;

    assign w_rd_idx  = if_req_addr[INDEX_WIDTH+1:2];
    assign w_req_tag = if_req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_unused  = ^if_req_addr[1:0];
    assign w_ready   = (r_state == ST_IDLE) && !flush;
    assign w_accept  = if_req_valid && w_ready;
    assign w_hit     = w_line_valid && (w_line_tag == w_req_tag);
    // Fill only on a done the FSM actually consumes (rdy-gated).
    assign w_we      = rdy && (r_state == ST_FETCH) && mc_done;

    icache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (ICACHE_INST_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_we),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (r_tag),
        .i_wr_data  (mc_data)
    );

    always_comb begin
        w_state_n     = r_state;
        w_rsp_valid_n = 1'b0;
        w_rsp_inst_n  = r_rsp_inst;
        w_mc_req_n    = r_mc_req;
        w_mc_addr_n   = r_mc_addr;
        w_drop_n      = r_drop;
        w_idx_n       = r_idx;
        w_tag_n       = r_tag;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_rsp_valid_n = 1'b1;
                        w_rsp_inst_n  = w_line_data;
                    end else begin
                        w_state_n   = ST_FETCH;
                        w_mc_req_n  = 1'b1;
                        w_mc_addr_n = {if_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_idx_n     = w_rd_idx;
                        w_tag_n     = w_req_tag;
                    end
                end
            end
            ST_FETCH: begin
                // The controller transfer always completes; flush only mutes it.
                if (flush) begin
                    w_drop_n = 1'b1;
                end
                if (mc_done) begin
                    w_state_n     = ST_IDLE;
                    w_mc_req_n    = 1'b0;
                    w_rsp_valid_n = !(r_drop || flush);
                    w_rsp_inst_n  = mc_data;
                    w_drop_n      = 1'b0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_inst  <= '0;
            r_mc_req    <= 1'b0;
            r_mc_addr   <= '0;
            r_drop      <= 1'b0;
            r_idx       <= '0;
            r_tag       <= '0;
        end else if (rdy) begin
            r_state     <= w_state_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_inst  <= w_rsp_inst_n;
            r_mc_req    <= w_mc_req_n;
            r_mc_addr   <= w_mc_addr_n;
            r_drop      <= w_drop_n;
            r_idx       <= w_idx_n;
            r_tag       <= w_tag_n;
        end
    end

    assign if_req_ready = w_ready;
    assign if_rsp_valid = r_rsp_valid;
    assign if_rsp_inst  = r_rsp_inst;
    assign mc_req       = r_mc_req;
    assign mc_addr      = r_mc_addr;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: vector table of fetches plus
// hand-written flush, rdy-stall and async-reset sequences.
module tb_icache_fetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic        flush;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          flush_at;
        bit          miss;
        bit          rsp;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[13];

    icache_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_inst  (if_rsp_inst),
        .flush        (flush),
        .mc_req       (mc_req),
        .mc_addr      (mc_addr),
        .mc_done      (mc_done),
        .mc_data      (mc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string nm);
        int bad;
        bad = 0;
        if_req_valid = 1'b1;
        if_req_addr  = v.addr;
        #1;
        chk({nm, " ready"}, {31'd0, if_req_ready}, 32'd1);
        step();
        if_req_valid = 1'b0;
        if (v.miss) begin
            for (int k = 0; k < v.lat; k++) begin
                if (!mc_req) bad++;
                if (mc_addr !== {v.addr[31:2], 2'b00}) bad++;
                if (if_rsp_valid) bad++;
                flush   = (k == v.flush_at);
                mc_done = (k == v.lat - 1);
                mc_data = mc_done ? v.data : 32'hFFFF_FFFF;
                step();
                flush   = 1'b0;
                mc_done = 1'b0;
            end
            chk({nm, " req_hold"}, bad, 0);
        end
        chk({nm, " rsp_valid"}, {31'd0, if_rsp_valid}, {31'd0, v.rsp});
        if (v.rsp) chk({nm, " inst"}, if_rsp_inst, v.inst);
        chk({nm, " mc_req_low"}, {31'd0, mc_req}, 32'd0);
        step();
        chk({nm, " pulse_end"}, {31'd0, if_rsp_valid}, 32'd0);
    endtask

    initial begin
        int   bad;
        vec_t v;

        vecs[0]  = '{32'h0000_0100, 32'h0000_0513, 4, -1, 1, 1, 32'h0000_0513};
        vecs[1]  = '{32'h0000_0102, 32'h0,         0, -1, 0, 1, 32'h0000_0513};
        vecs[2]  = '{32'h0000_0500, 32'hAAAA_0001, 2, -1, 1, 1, 32'hAAAA_0001};
        vecs[3]  = '{32'h0000_0100, 32'h0000_0513, 3, -1, 1, 1, 32'h0000_0513};
        vecs[4]  = '{32'h0000_0200, 32'h1234_5678, 4,  1, 1, 0, 32'h0};
        vecs[5]  = '{32'h0000_0200, 32'h0,         0, -1, 0, 1, 32'h1234_5678};
        vecs[6]  = '{32'h0000_0204, 32'h0BAD_F00D, 1, -1, 1, 1, 32'h0BAD_F00D};
        vecs[7]  = '{32'h0000_0300, 32'hCAFE_BABE, 3,  2, 1, 0, 32'h0};
        vecs[8]  = '{32'h0000_0300, 32'h0,         0, -1, 0, 1, 32'hCAFE_BABE};
        vecs[9]  = '{32'hFFFF_FFFE, 32'hDEAD_BEEF, 2, -1, 1, 1, 32'hDEAD_BEEF};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0,         0, -1, 0, 1, 32'hDEAD_BEEF};
        vecs[11] = '{32'h0000_0500, 32'hAAAA_0001, 2, -1, 1, 1, 32'hAAAA_0001};
        vecs[12] = '{32'h0000_0102, 32'h0000_0513, 2, -1, 1, 1, 32'h0000_0513};

        rst          = 1'b1;
        rdy          = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr  = 32'h0;
        flush        = 1'b0;
        mc_done      = 1'b0;
        mc_data      = 32'h0;
        #12;
        chk("reset rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("reset rsp_inst", if_rsp_inst, 32'd0);
        chk("reset mc_req", {31'd0, mc_req}, 32'd0);
        chk("reset mc_addr", mc_addr, 32'd0);
        chk("reset ready", {31'd0, if_req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush in IDLE blocks acceptance of a would-be hit
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0204;
        flush        = 1'b1;
        #1;
        chk("idle_flush ready", {31'd0, if_req_ready}, 32'd0);
        step();
        if_req_valid = 1'b0;
        flush        = 1'b0;
        chk("idle_flush rsp", {31'd0, if_rsp_valid}, 32'd0);
        chk("idle_flush mc_req", {31'd0, mc_req}, 32'd0);

        // rdy stall mid-FETCH with an ignored done pulse
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0400;
        step();
        if_req_valid = 1'b0;
        chk("stall mc_req", {31'd0, mc_req}, 32'd1);
        chk("stall mc_addr", mc_addr, 32'h0000_0400);
        step();
        bad = 0;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mc_done = (k == 1);
            mc_data = 32'h1111_1111;
            step();
            mc_done = 1'b0;
            if (!mc_req || if_rsp_valid) bad++;
        end
        rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            if (!mc_req || if_rsp_valid) bad++;
        end
        chk("stall hold", bad, 0);
        mc_done = 1'b1;
        mc_data = 32'h0000_0067;
        step();
        mc_done = 1'b0;
        chk("stall rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
        chk("stall inst", if_rsp_inst, 32'h0000_0067);
        chk("stall mc_req_low", {31'd0, mc_req}, 32'd0);
        step();
        v = '{32'h0000_0400, 32'h0, 0, -1, 0, 1, 32'h0000_0067};
        apply(v, "stall_hit");

        // Async reset between edges while fetching
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0600;
        step();
        if_req_valid = 1'b0;
        chk("arst pre mc_req", {31'd0, mc_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst mc_req", {31'd0, mc_req}, 32'd0);
        chk("arst mc_addr", mc_addr, 32'd0);
        chk("arst rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{32'h0000_0100, 32'h0000_0513, 2, -1, 1, 1, 32'h0000_0513};
        apply(v, "post_arst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller's instruction port.
- Serves 32-bit instruction fetches: a hit responds in 1 cycle.
- On a miss it acts as the initiator of the memory controller's instruction handshake. It holds a request with a word address until the controller pulses done with the assembled 32-bit word, then fills the line and returns the word.
- Supports a flush from branch redirect that suppresses delivery of a stale in-flight fill.

Parameters:
- INDEX_WIDTH, 8, log2 of line count (256 one-word lines)
- ADDR_WIDTH, 32, fetch address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global ready; when low, all state holds
- if_req_valid  in  1  IF presents a fetch address
- if_req_addr  in  32  fetch PC; bits [1:0] ignored
- if_req_ready  out  1  cache accepts a request this cycle
- if_rsp_valid  out  1  one-cycle pulse: instruction valid
- if_rsp_inst  out  32  instruction word
- flush  in  1  redirect: drop pending/in-flight response
- mc_req  out  1  request to memory controller, level-held
- mc_addr  out  32  word-aligned fetch address, {tag,index,2'b00}
- mc_done  in  1  controller completion pulse
- mc_data  in  32  fetched word, valid in the mc_done cycle

Behaviour:
- Address split: index = addr[INDEX_WIDTH+1:2]; tag = addr[31:INDEX_WIDTH+2], 22 bits by default.
- Reset (async, rst=1):
  - all valid bits cleared
  - state=IDLE
  - if_rsp_valid=0, if_rsp_inst=0
  - mc_req=0, mc_addr=0
  - drop=0
  - tag/data arrays are not reset.
- rdy=0: no state, array or output register changes. mc_done is ignored while rdy=0.
- if_req_ready = (state==IDLE) && !flush.
- IDLE:
  - On posedge with if_req_valid && if_req_ready, look up index.
  - Hit (valid && tag match): next cycle if_rsp_valid=1, if_rsp_inst=data[index]; stay IDLE.
  - Miss: next cycle state=FETCH, mc_req=1, mc_addr=word-aligned req addr, latch index/tag.
- FETCH:
  - mc_req stays 1 and mc_addr stays stable until mc_done is sampled 1.
  - On mc_done: write data[index]=mc_data, tag[index]=tag, valid[index]=1.
  - Next cycle: mc_req=0, state=IDLE, if_rsp_valid=!drop with if_rsp_inst=mc_data; drop cleared.
  - Miss latency is controller latency plus 1 cycle.
- flush:
  - In IDLE it cancels any response scheduled for the next cycle (if_rsp_valid forced 0) and blocks acceptance.
  - In FETCH the controller transaction is never aborted, because the byte sequencer must finish. Set drop=1; the line is still filled, but no response is emitted.
  - flush and mc_done in the same cycle: the fill happens, no response is emitted.
- if_rsp_valid is a single-cycle pulse; it defaults to 0 in every cycle not listed above.
- mc_req never asserts in the cycle immediately following a mc_done; the minimum gap is 1 cycle. This lets the controller reset its byte offset.
- No writes, no coherence: instruction memory is read-only.

Decomposition:
- Shared package / defines.v additions:
  - ICACHE_INDEX_WIDTH, ICACHE_TAG_WIDTH
  - state encodings ST_IDLE=1'b0, ST_FETCH=1'b1
  - macro for the instruction-word width
- One natural sub-module, icache_array: valid/tag/data storage with combinational read, synchronous write, and async clear of valid bits.

Test Plan:
- Cold miss: rst, then if_req_addr=0x0000_0100; controller model returns mc_done with mc_data=0x0000_0513 after 4 cycles -> mc_req high with mc_addr=0x100 until done; one cycle later if_rsp_valid=1, if_rsp_inst=0x00000513; mc_req=0.
- Hit: re-request 0x0000_0102 -> if_rsp_valid next cycle with 0x00000513, mc_req stays 0.
- Conflict eviction: request 0x0000_0500 (same index 0x40, different tag) -> miss, refill. Then 0x100 misses again.
- Flush during fill: miss on 0x200, flush at cycle 2 of FETCH -> mc_req held until mc_done, no if_rsp_valid. A later request to 0x200 hits.
- rdy stall: deassert rdy for 3 cycles mid-FETCH with mc_done pulsed while rdy=0 -> no state change and the pulse is ignored. Completes on a later done after rdy returns.
- Async reset mid-FETCH: assert rst between clock edges -> mc_req=0 immediately; all lines invalid, so a subsequent request to 0x100 misses.
